// File: rtl/encoder16_4_sync.sv
// Registered 16-to-4 priority encoder for active-low request lines: two-flop
// synchroniser, debounce, lowest-index priority and a valid/ack handshake.
module encoder16_4_sync #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [16:1] n_req,
   input  logic        ack,
   output logic [3:0]  code,
   output logic        valid,
   output logic        multi
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, REPORT, RELEASE} state_t;

   state_t        state;
   logic [16:1]   sync1;
   logic [16:1]   sync2;
   logic [16:1]   snap;
   logic [CW-1:0] cnt;
   logic [3:0]    prio_code;
   logic [4:0]    zeros;

   // Scan from line 16 down so the lowest active index is written last and wins.
   always_comb begin
      prio_code = '0;
      zeros     = '0;
      for (int unsigned k = 0; k < 16; k++) begin
         if (!snap[16-k]) begin
            prio_code = 4'(15 - k);
            zeros     = zeros + 5'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
         snap  <= '1;
         cnt   <= '0;
         code  <= '0;
         valid <= 1'b0;
         multi <= 1'b0;
         state <= IDLE;
      end else begin
         sync1 <= n_req;
         sync2 <= sync1;
         case (state)
            IDLE: begin
               if (sync2 != '1) begin
                  snap  <= sync2;
                  cnt   <= '0;
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (sync2 != snap) begin
                  if (sync2 == '1) begin
                     state <= IDLE;
                  end else begin
                     snap <= sync2;
                     cnt  <= '0;
                  end
               end else if (cnt == CNT_LAST) begin
                  code  <= prio_code;
                  multi <= (zeros > 5'd1);
                  valid <= 1'b1;
                  state <= REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REPORT: begin
               if (ack) begin
                  valid <= 1'b0;
                  cnt   <= '0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               // Any active line restarts the release count; no report from here.
               if (sync2 == '1) begin
                  if (cnt == CNT_LAST) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder16_4_sync.sv
// Directed self-checking bench for encoder16_4_sync (DEB_CYCLES=4 main DUT,
// DEB_CYCLES=1 companion DUT on the same request lines).
module tb_encoder16_4_sync;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        ack;
   logic        ack1;
   logic [16:1] n_req;
   logic [3:0]  code, code1;
   logic        valid, valid1;
   logic        multi, multi1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   encoder16_4_sync #(.DEB_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .n_req(n_req), .ack(ack),
      .code(code), .valid(valid), .multi(multi)
   );

   encoder16_4_sync #(.DEB_CYCLES(1)) dut1 (
      .CLOCK_50(CLOCK_50), .reset(reset), .n_req(n_req), .ack(ack1),
      .code(code1), .valid(valid1), .multi(multi1)
   );

   function automatic logic [16:1] line(input int unsigned i);
      logic [15:0] one;
      one  = 16'h1;
      line = ~(one << (i - 1));
   endfunction

   // Model of the 4-to-16 active-low decoder feeding the loopback test.
   function automatic logic [16:1] dec(input logic [3:0] sw);
      logic [15:0] v;
      v = '1;
      v[sw] = 1'b0;
      dec = v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (!valid && n < maxc) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic release_idle();
      n_req = '1;
      repeat (10) tick();
   endtask

   initial begin
      int n;
      int cnt;
      logic bad;
      logic [6:0] v1;

      reset = 1'b1;
      ack   = 1'b0;
      ack1  = 1'b1;
      n_req = '1;

      // Reset then idle
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_valid", valid, 0);
      chk("rst_code",  code,  0);
      chk("rst_multi", multi, 0);
      bad = 1'b0;
      repeat (20) begin
         tick();
         bad |= valid | multi | (code != 4'd0);
      end
      chk("idle_quiet", bad, 0);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst2_valid", valid, 0);
      chk("rst2_code",  code,  0);

      // Single press on line 6, exact latency, DEB_CYCLES=1 companion pulse
      n_req = line(6);
      bad = 1'b0;
      v1  = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         bad |= valid;
         v1[k] = valid1;
      end
      tick();
      v1[6] = valid1;
      chk("t2_early",   bad,   0);
      chk("t2_valid",   valid, 1);
      chk("t2_code",    code,  5);
      chk("t2_multi",   multi, 0);
      chk("deb1_pulse", v1,    7'b0001000);
      chk("deb1_code",  code1, 5);
      cnt = 0;
      repeat (10) begin
         tick();
         if (valid && code == 4'd5 && !multi) cnt++;
      end
      chk("t2_hold", cnt, 10);
      pulse_ack();
      chk("t2_ack_drop",  valid, 0);
      chk("t2_code_kept", code,  5);

      // Press during RELEASE delays the return and gives no report
      cnt = 0;
      n_req = '1;
      repeat (3) begin tick(); if (valid) cnt++; end
      n_req = line(2);
      repeat (3) begin tick(); if (valid) cnt++; end
      n_req = '1;
      repeat (12) begin tick(); if (valid) cnt++; end
      chk("rel_press_norpt", cnt, 0);

      // Multi-hot, then line change during REPORT ignored
      n_req = line(3) & line(12);
      wait_valid(30, n);
      chk("multi_lat",   n,     7);
      chk("multi_code",  code,  2);
      chk("multi_flag",  multi, 1);
      n_req = line(1);
      cnt = 0;
      repeat (5) begin
         tick();
         if (valid && code == 4'd2 && multi) cnt++;
      end
      chk("report_frozen", cnt, 5);
      pulse_ack();
      release_idle();

      n_req = line(16);
      wait_valid(30, n);
      chk("l16_lat",   n,     7);
      chk("l16_code",  code,  15);
      chk("l16_multi", multi, 0);
      pulse_ack();
      release_idle();

      // Bounce on line 9, then hold
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         n_req = (i % 2 == 0) ? line(9) : 16'hFFFF;
         tick();
         bad |= valid;
      end
      chk("bounce_norpt", bad, 0);
      n_req = line(9);
      wait_valid(30, n);
      chk("bounce_lat",  n,    7);
      chk("bounce_code", code, 8);
      pulse_ack();
      cnt = 0;
      repeat (20) begin tick(); if (valid) cnt++; end
      chk("bounce_once", cnt, 0);
      release_idle();

      // ack while idle ignored; no repeat while held; second press reports
      ack = 1'b1;
      bad = 1'b0;
      repeat (5) begin tick(); bad |= valid; end
      ack = 1'b0;
      chk("ack_idle", bad, 0);
      n_req = line(1);
      wait_valid(30, n);
      chk("l1_lat",  n,    7);
      chk("l1_code", code, 0);
      ack = 1'b1;
      tick();
      chk("l1_drop", valid, 0);
      cnt = 0;
      repeat (50) begin tick(); if (valid) cnt++; end
      chk("no_repeat", cnt, 0);
      ack = 1'b0;
      n_req = '1;
      repeat (8) tick();
      n_req = line(1);
      wait_valid(30, n);
      chk("l1b_lat",  n,    7);
      chk("l1b_code", code, 0);
      pulse_ack();
      release_idle();

      // Loopback through the decoder model with ack tied high
      ack = 1'b1;
      for (int sw = 0; sw < 16; sw++) begin
         n_req = dec(4'(sw));
         wait_valid(30, n);
         chk($sformatf("loop_code_%0d", sw), {valid, code}, {1'b1, 4'(sw)});
         release_idle();
      end
      ack = 1'b0;

      // Reset while valid
      n_req = line(4);
      wait_valid(30, n);
      chk("pre_rst_valid", valid, 1);
      chk("pre_rst_code",  code,  3);
      reset = 1'b1;
      n_req = '1;
      tick();
      chk("rst_valid_drop", valid, 0);
      chk("rst_code_clr",   code,  0);
      reset = 1'b0;
      n_req = line(7);
      wait_valid(30, n);
      chk("post_rst_lat",  n,    7);
      chk("post_rst_code", code, 6);
      pulse_ack();
      release_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
